// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and counter sizing for the
// multi-cycle ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    IT_SLL,
    IT_SRL,
    IT_SRA,
    IT_MUL
  } iter_op_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1101;

  // Counter must hold WIDTH itself (multiply step count), hence the +1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative shift / shift-add multiply datapath for alu_mc.
// Multiplier registers and the b port exist only with ALU_MC_MUL_EN defined.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  iter_op_t                 op,
  input  logic [WIDTH-1:0]         a,
`ifdef ALU_MC_MUL_EN
  input  logic [WIDTH-1:0]         b,
`endif
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     last,
  output logic [WIDTH-1:0]         result
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             sign;
  iter_op_t         op_q;
  logic [WIDTH-1:0] step;

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
`endif

  always_comb begin
    step = acc;
    case (op_q)
      IT_SLL:  step = {acc[WIDTH-2:0], 1'b0};
      IT_SRL:  step = {1'b0, acc[WIDTH-1:1]};
      IT_SRA:  step = {sign, acc[WIDTH-1:1]};
`ifdef ALU_MC_MUL_EN
      IT_MUL:  step = acc + (mplier[0] ? mcand : '0);
`endif
      default: step = acc;
    endcase
  end

  // result is the value after the step taken on the edge where last is high
  assign last   = (cnt == CW'(1));
  assign result = step;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      cnt  <= '0;
      sign <= 1'b0;
      op_q <= IT_SLL;
`ifdef ALU_MC_MUL_EN
      mcand  <= '0;
      mplier <= '0;
`endif
    end else if (start) begin
      op_q <= op;
      sign <= a[WIDTH-1];
`ifdef ALU_MC_MUL_EN
      mcand  <= a;
      mplier <= b;
      acc    <= (op == IT_MUL) ? '0 : a;
      cnt    <= (op == IT_MUL) ? CW'(WIDTH) : CW'(shamt);
`else
      acc <= a;
      cnt <= CW'(shamt);
`endif
    end else if (cnt != '0) begin
      acc <= step;
      cnt <= cnt - CW'(1);
`ifdef ALU_MC_MUL_EN
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shifts and an
// optional iterative multiplier (enabled by defining ALU_MC_MUL_EN).
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [3:0]       ALUcontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] fast_res;
  logic             fast_ill;
  logic             need_iter;
  iter_op_t         iter_op;
  logic [SW-1:0]    shamt;
  logic             iter_last;
  logic [WIDTH-1:0] iter_res;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign shamt    = rs2[SW-1:0];

  // Shifts by zero complete immediately with rs1 as the result.
  always_comb begin
    fast_res  = '0;
    fast_ill  = 1'b0;
    need_iter = 1'b0;
    iter_op   = IT_SLL;
    case (ALUcontrol)
      OP_ADD: fast_res = rs1 + rs2;
      OP_SUB: fast_res = rs1 - rs2;
      OP_AND: fast_res = rs1 & rs2;
      OP_OR:  fast_res = rs1 | rs2;
      OP_XOR: fast_res = rs1 ^ rs2;
      OP_SLT: fast_res = WIDTH'($signed(rs1) < $signed(rs2));
      OP_SLL: begin fast_res = rs1; iter_op = IT_SLL; need_iter = (shamt != '0); end
      OP_SRL: begin fast_res = rs1; iter_op = IT_SRL; need_iter = (shamt != '0); end
      OP_SRA: begin fast_res = rs1; iter_op = IT_SRA; need_iter = (shamt != '0); end
`ifdef ALU_MC_MUL_EN
      OP_MUL: begin iter_op = IT_MUL; need_iter = 1'b1; end
`endif
      default: fast_ill = 1'b1;
    endcase
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && need_iter),
    .op     (iter_op),
    .a      (rs1),
`ifdef ALU_MC_MUL_EN
    .b      (rs2),
`endif
    .shamt  (shamt),
    .last   (iter_last),
    .result (iter_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (need_iter) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= fast_res;
              zero      <= (fast_res == '0);
              illegal   <= fast_ill;
            end
          end
        end
        BUSY: begin
          if (iter_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= iter_res;
            zero      <= (iter_res == '0);
            illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=64): directed cases plus random ops
// checked against a plain-arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        zero;
  logic        illegal;

  alu_mc #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1        (rs1),
    .rs2        (rs2),
    .ALUcontrol (alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .zero       (zero),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        ill;
    int          lat;
    int          acc;
    bit          hold;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          have_cur = 0;
  logic [63:0] cur_out;
  logic        cur_zero;
  logic        cur_ill;
  int          hold_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(b[5:0]);
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b0100: begin r = a << sh; lat = sh + 1; end
      4'b0101: begin r = a >> sh; lat = sh + 1; end
      4'b1101: begin r = 64'($signed(a) >>> sh); lat = sh + 1; end
`ifdef ALU_MC_MUL_EN
      4'b1000: begin r = a * b; lat = 65; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input bit push, input bit hold);
    exp_t e;
    int   guard;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = op;
    rs1         = a;
    rs2         = b;
    guard       = 0;
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stuck at %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      model(op, a, b, e.r, e.ill, e.lat);
      e.z    = (e.r == 64'd0);
      e.acc  = cyc;
      e.hold = hold;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1      = {$urandom, $urandom};
    rs2      = {$urandom, $urandom};
  endtask

  task automatic monitor_step();
    exp_t e;
    if (reset) have_cur = 0;
    if (out_valid) begin
      chk("in_ready_while_valid", 64'(in_ready), 64'd0);
      if (!have_cur) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: out=%h with nothing outstanding", out);
        end else begin
          e = sbq.pop_front();
          chk("out", out, e.r);
          chk("zero", 64'(zero), 64'(e.z));
          chk("illegal", 64'(illegal), 64'(e.ill));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          hold_left = e.hold ? 3 : 0;
        end
        cur_out  = out;
        cur_zero = zero;
        cur_ill  = illegal;
        have_cur = 1;
      end else begin
        chk("hold_out", out, cur_out);
        chk("hold_zero", 64'(zero), 64'(cur_zero));
        chk("hold_illegal", 64'(illegal), 64'(cur_ill));
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_ready) have_cur = 0;
    end else begin
      chk("idle_out", out, 64'd0);
      chk("idle_flags", {62'd0, zero, illegal}, 64'd0);
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [3:0] op_list [10];
    logic [3:0] op;
    logic [63:0] a;
    logic [63:0] b;
    int guard;

    op_list = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                4'b0111, 4'b0100, 4'b0101, 4'b1101, 4'b1000};
    reset       = 1'b1;
    in_valid    = 1'b0;
    rs1         = '0;
    rs2         = '0;
    alu_control = '0;
    out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out", out, 64'd0);
    chk("reset_flags", {62'd0, zero, illegal}, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    issue(4'b0010, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
    issue(4'b0110, 64'h1234, 64'h1234, 1, 1);
    issue(4'b1101, 64'h8000_0000_0000_0000, 64'd4, 1, 0);
    issue(4'b1101, 64'h8000_0000_0000_0000, 64'd0, 1, 0);
    issue(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1, 0);
    issue(4'b1111, 64'h1234_5678, 64'h9ABC, 1, 0);
    issue(4'b0100, 64'h1, 64'd63, 1, 0);
    issue(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);

    // Reset in the middle of a long operation: its result must never appear.
`ifdef ALU_MC_MUL_EN
    issue(4'b1000, 64'hDEAD_BEEF, 64'h1234_5678, 0, 0);
`else
    issue(4'b0101, 64'hDEAD_BEEF, 64'd50, 0, 0);
`endif
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midop_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midop_reset_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      int k;
      k  = $urandom_range(0, 11);
      op = (k < 10) ? op_list[k] : 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
      issue(op, a, b, 1, ($urandom_range(0, 9) == 0));
    end

    guard = 0;
    while ((sbq.size() != 0 || have_cur || out_valid) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0 || have_cur) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port rs1  input  WIDTH  operand A.
REQ-007 SHALL have port rs2  input  WIDTH  operand B; shift amount in bits [log2(WIDTH)-1:0].
REQ-008 SHALL have port ALUcontrol  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out  output  WIDTH  result.
REQ-012 SHALL have port zero  output  1  out equals 0.
REQ-013 SHALL have port illegal  output  1  opcode was not supported.

Function
REQ-014 SHALL decode opcodes as follows: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 0111 SLT (signed, result 1/0), 0100 SLL, 0101 SRL, 1101 SRA, 1000 MUL (low WIDTH bits of the product).
REQ-015 SHALL treat any other opcode as illegal: out=0, zero=1, illegal=1, latency 1.
REQ-016 SHALL use the states IDLE, BUSY and DONE.
REQ-017 SHALL assert in_ready only in IDLE; a request is accepted when in_valid&&in_ready, and operands and opcode are latched at that point.
REQ-018 SHALL compute ADD/SUB/AND/OR/XOR/SLT/illegal ops at acceptance and go IDLE->DONE, giving out_valid on the cycle after acceptance (latency 1).
REQ-019 SHALL perform shifts iteratively, one bit per cycle in BUSY, with a down-counter loaded with the shift amount; a shift amount of 0 goes straight to DONE (latency 1); otherwise latency is shamt+1.
REQ-020 SHALL fill SRA with the latched sign bit.
REQ-021 SHALL perform MUL as iterative shift-add over WIDTH cycles in BUSY; latency WIDTH+1; the product wraps modulo 2^WIDTH.
REQ-022 SHALL wrap ADD/SUB modulo 2^WIDTH and SHALL NOT report an overflow flag.
REQ-023 SHALL hold out, zero, illegal and out_valid stable in DONE until out_ready=1; on out_valid&&out_ready it returns to IDLE the next cycle.
REQ-024 SHALL ignore in_valid while in BUSY or DONE (no queuing); in_ready=0 there.
REQ-025 SHALL compute zero from the final out of the current operation.
REQ-026 SHALL drive out, zero and illegal to 0 whenever out_valid=0.

Reset
REQ-027 SHALL, while reset=1 on a clock edge, enter IDLE with out_valid=0, out=0, zero=0, illegal=0, counter=0, and in_ready=1 from the first cycle after reset deasserts.
REQ-028 SHALL, when reset is applied in BUSY or DONE, abandon the operation and never present its result.

Configuration
REQ-029 SHALL, with ALU_MC_MUL_EN defined, include the iterative multiplier and decode 1000 as MUL.
REQ-030 SHALL, without ALU_MC_MUL_EN, omit the multiplier logic entirely and treat 1000 as illegal per REQ-015.

Structure
REQ-031 SHALL take opcode constants, the state enumeration and the counter-width constant ($clog2(WIDTH)+1) from the shared package alu_pkg.
REQ-032 SHALL place the iterative shift/multiply datapath (operand registers, counter and the step function) in one sub-module, alu_iter; alu_mc holds the FSM, the single-cycle ops and the handshake.

Verification (WIDTH=64)
REQ-033 SHALL cover ADD: rs1=5, rs2=-3, op 0010 -> out=2, zero=0, out_valid one cycle after acceptance.
REQ-034 SHALL cover SUB to zero and back-pressure: rs1=rs2=0x1234, op 0110, out_ready=0 for 3 cycles -> out=0 and zero=1 held stable, in_ready=0 until the handshake completes.
REQ-035 SHALL cover SRA: rs1=0x8000000000000000, rs2=4, op 1101 -> out=0xF800000000000000, out_valid 5 cycles after acceptance; the same case with shamt 0 gives latency 1.
REQ-036 SHALL cover MUL with ALU_MC_MUL_EN: rs1=0xFFFFFFFFFFFFFFFF, rs2=3 -> out=0xFFFFFFFFFFFFFFFD after 65 cycles; without the macro -> illegal=1, out=0, latency 1.
REQ-037 SHALL cover reset mid-operation: reset asserted 10 cycles into a MUL -> next cycle IDLE, out_valid=0, in_ready=1, and no stale result afterwards.
REQ-038 SHALL cover an illegal opcode: op 1111 -> illegal=1, zero=1, out=0.
